// File: rtl/dht11_poll_pkg.sv
// -----------------------------------------------------------------------------
// dht11_poll_pkg
// Shared definitions for the dht11 poller.
//   - poll_state_e : FSM states, encoded with the values shown on db_estado
//   - TEMP_MAX / UMID_MAX : plausibility limits on the integer part of a reading
//   - cnt_width / rty_width : width helpers for the shared timer and retry count
//   - reading_in_range : plausibility test used when the range check is built in
// -----------------------------------------------------------------------------
package dht11_poll_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_START   = 4'd1,
    ST_WAIT    = 4'd2,
    ST_CAPTURE = 4'd3,
    ST_HOLD    = 4'd4
  } poll_state_e;

  localparam logic [7:0] TEMP_MAX = 8'd50;
  localparam logic [7:0] UMID_MAX = 8'd95;

  // Counter width able to reach (max limit - 1); never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  // Retry counter width able to hold MAX_RETRIES; never narrower than one bit.
  function automatic int rty_width(input int max_retries);
    int w;
    w = $clog2(max_retries + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Only the integer byte (bits 15:8) is meaningful for the plausibility test.
  function automatic logic reading_in_range(input logic [15:0] temp,
                                            input logic [15:0] umid);
    return (temp[15:8] <= TEMP_MAX) && (umid[15:8] <= UMID_MAX);
  endfunction

endpackage

// File: rtl/dht11_poll_timer.sv
// -----------------------------------------------------------------------------
// dht11_poll_timer
// Free-running up-counter shared by the WAIT timeout and the HOLD gap.
// Ports:
//   clock, reset  : system clock, synchronous active-low reset
//   i_clear       : force the count to zero (has priority over i_enable)
//   i_enable      : advance the count by one
//   i_limit       : value compared against the count
//   o_count       : current count
//   o_eq          : count equals i_limit
// -----------------------------------------------------------------------------
module dht11_poll_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_count,
  output logic         o_eq
);

  logic [W-1:0] r_count;

  // Count register: clear wins over enable, otherwise hold.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
  assign o_eq    = (r_count == i_limit);

endmodule

// File: rtl/dht11_poller.sv
// -----------------------------------------------------------------------------
// dht11_poller
// Sequencer in front of the dht11 driver: issues one-cycle start pulses
// (periodic while enable is high, or on req), enforces a minimum gap after
// every attempt, times out silent reads, retries failures and keeps the last
// good reading.
//
// Build option: DHT11_POLL_RANGE_CHECK_EN -- when defined, an implausible
// pronto (temp > 50 or umid > 95 in the integer byte) is handled as an error.
//
// Ports:
//   clock, reset           : system clock, synchronous active-low reset
//   enable                 : periodic polling when high
//   req                    : one-cycle manual read request
//   sensor_pronto/_error   : completion / error pulses from the dht11 driver
//   sensor_temp/_umid      : reading presented by the dht11 driver
//   sensor_start           : one-cycle start pulse to the dht11 driver
//   temperatura/umidade    : last good reading
//   valid                  : at least one good read since reset
//   busy                   : START, WAIT or CAPTURE in progress
//   fail                   : retries exhausted; cleared by the next good read
//   db_estado              : state code for a hex display
// -----------------------------------------------------------------------------
module dht11_poller
  import dht11_poll_pkg::*;
#(
  parameter int INTERVAL_CYCLES = 100000000,
  parameter int TIMEOUT_CYCLES  = 2500000,
  parameter int MAX_RETRIES     = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        req,
  input  logic        sensor_pronto,
  input  logic        sensor_error,
  input  logic [15:0] sensor_temp,
  input  logic [15:0] sensor_umid,
  output logic        sensor_start,
  output logic [15:0] temperatura,
  output logic [15:0] umidade,
  output logic        valid,
  output logic        busy,
  output logic        fail,
  output logic [3:0]  db_estado
);

  localparam int CNT_W = cnt_width(INTERVAL_CYCLES, TIMEOUT_CYCLES);
  localparam int RTY_W = rty_width(MAX_RETRIES);

  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INT_LIM = CNT_W'(INTERVAL_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRIES);

  poll_state_e      r_state;
  logic [RTY_W-1:0] r_retries;
  logic             r_retry_pending;
  logic             r_pending;
  logic             r_start;
  logic [15:0]      r_temp;
  logic [15:0]      r_umid;
  logic             r_valid;
  logic             r_busy;
  logic             r_fail;

  logic [CNT_W-1:0] w_count;
  logic             w_interval_done;
  logic             w_in_wait;
  logic             w_in_hold;
  logic             w_timeout;
  logic             w_range_ok;
  logic             w_pronto_ok;
  logic             w_attempt_fail;
  logic             w_tmr_en;
  logic             w_tmr_clr;

`ifdef DHT11_POLL_RANGE_CHECK_EN
  assign w_range_ok = reading_in_range(sensor_temp, sensor_umid);
`else
  assign w_range_ok = 1'b1;
`endif

  assign w_in_wait      = (r_state == ST_WAIT);
  assign w_in_hold      = (r_state == ST_HOLD);
  assign w_timeout      = (w_count == TMO_LIM);
  // A good pronto beats any simultaneous error or timeout.
  assign w_pronto_ok    = sensor_pronto & w_range_ok;
  assign w_attempt_fail = sensor_error | (sensor_pronto & ~w_range_ok) | w_timeout;

  // The timer only runs in WAIT/HOLD and is cleared on every exit from them,
  // so it restarts from zero and never wraps.
  assign w_tmr_en  = w_in_wait | w_in_hold;
  assign w_tmr_clr = ~w_tmr_en
                   | (w_in_wait & (w_pronto_ok | w_attempt_fail))
                   | (w_in_hold & w_interval_done);

  dht11_poll_timer #(
    .W (CNT_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_tmr_clr),
    .i_enable (w_tmr_en),
    .i_limit  (INT_LIM),
    .o_count  (w_count),
    .o_eq     (w_interval_done)
  );

  // Poll sequencer; outputs are registered alongside the state transition.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_retries       <= '0;
      r_retry_pending <= 1'b0;
      r_pending       <= 1'b0;
      r_start         <= 1'b0;
      r_temp          <= 16'h0000;
      r_umid          <= 16'h0000;
      r_valid         <= 1'b0;
      r_busy          <= 1'b0;
      r_fail          <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_pending || req || r_retry_pending || enable) begin
            r_state   <= ST_START;
            r_start   <= 1'b1;
            r_busy    <= 1'b1;
            r_pending <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_START: begin
          r_state <= ST_WAIT;
          r_busy  <= 1'b1;
        end
        ST_WAIT: begin
          if (w_pronto_ok) begin
            r_state <= ST_CAPTURE;
            r_busy  <= 1'b1;
          end else if (w_attempt_fail) begin
            r_state <= ST_HOLD;
            r_busy  <= 1'b0;
            if (r_retries < RTY_MAX) begin
              r_retries       <= r_retries + RTY_W'(1);
              r_retry_pending <= 1'b1;
            end else begin
              r_fail          <= 1'b1;
              r_retries       <= '0;
              r_retry_pending <= 1'b0;
            end
          end else begin
            r_state <= ST_WAIT;
            r_busy  <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          // The driver keeps its reading stable here, so sample it now.
          r_temp          <= sensor_temp;
          r_umid          <= sensor_umid;
          r_valid         <= 1'b1;
          r_fail          <= 1'b0;
          r_retries       <= '0;
          r_retry_pending <= 1'b0;
          r_state         <= ST_HOLD;
          r_busy          <= 1'b0;
        end
        ST_HOLD: begin
          // A request during the gap is remembered, never acted on early.
          if (req) begin
            r_pending <= 1'b1;
          end else begin
            r_pending <= r_pending;
          end
          if (w_interval_done) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_HOLD;
          end
          r_busy <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sensor_start = r_start;
  assign temperatura  = r_temp;
  assign umidade      = r_umid;
  assign valid        = r_valid;
  assign busy         = r_busy;
  assign fail         = r_fail;
  assign db_estado    = r_state;

endmodule

// File: tb/tb_dht11_poller.sv
// -----------------------------------------------------------------------------
// tb_dht11_poller
// Self-checking bench: a sensor model answers each start according to a mode,
// pushes the reading it expects to be captured into exp_q, and a monitor
// pushes every capture the poller makes into act_q. A table of single reads
// is applied in a loop; periodic polling, req-during-HOLD and reset-in-WAIT
// are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_dht11_poller;

  localparam int INTERVAL = 20;
  localparam int TIMEOUT  = 10;
  localparam int RETRIES  = 2;

`ifdef DHT11_POLL_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  // Model modes: 0 good pronto, 1 silent, 2 pronto+error, 3 out-of-range pronto, 4 error
  typedef struct {
    int          mode;
    logic [15:0] temp;
    logic [15:0] umid;
    int          starts;
    logic [15:0] e_temp;
    logic [15:0] e_umid;
    logic        e_valid;
    logic        e_fail;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        req;
  logic        sensor_pronto;
  logic        sensor_error;
  logic [15:0] sensor_temp;
  logic [15:0] sensor_umid;
  logic        sensor_start;
  logic [15:0] temperatura;
  logic [15:0] umidade;
  logic        valid;
  logic        busy;
  logic        fail;
  logic [3:0]  db_estado;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cnt = 0;
  int          start_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];
  logic [3:0]  prev_estado = 4'd0;

  int          m_mode = 0;
  logic [15:0] m_temp = 16'h0000;
  logic [15:0] m_umid = 16'h0000;

  vec_t tbl[7];

  dht11_poller #(
    .INTERVAL_CYCLES (INTERVAL),
    .TIMEOUT_CYCLES  (TIMEOUT),
    .MAX_RETRIES     (RETRIES)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .req           (req),
    .sensor_pronto (sensor_pronto),
    .sensor_error  (sensor_error),
    .sensor_temp   (sensor_temp),
    .sensor_umid   (sensor_umid),
    .sensor_start  (sensor_start),
    .temperatura   (temperatura),
    .umidade       (umidade),
    .valid         (valid),
    .busy          (busy),
    .fail          (fail),
    .db_estado     (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: records start pulses and every completed capture.
  always @(negedge clock) begin
    if (sensor_start) begin
      start_cnt <= start_cnt + 1;
      start_q.push_back(cyc);
    end
    if (prev_estado == 4'd3 && db_estado == 4'd4) begin
      act_q.push_back({temperatura, umidade});
    end
    prev_estado <= db_estado;
  end

  // Sensor model: answers in the fifth WAIT cycle after a start.
  initial begin
    sensor_pronto = 1'b0;
    sensor_error  = 1'b0;
    sensor_temp   = 16'h0000;
    sensor_umid   = 16'h0000;
    forever begin
      @(negedge clock);
      if (sensor_start && m_mode != 1) begin
        repeat (5) @(negedge clock);
        sensor_temp   = m_temp;
        sensor_umid   = m_umid;
        sensor_pronto = (m_mode != 4);
        sensor_error  = (m_mode == 2 || m_mode == 4);
        if (m_mode == 0 || m_mode == 2 || (m_mode == 3 && !RANGE_EN)) begin
          exp_q.push_back({m_temp, m_umid});
        end
        @(negedge clock);
        sensor_pronto = 1'b0;
        sensor_error  = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare captured readings against the model's expectations.
  task automatic drain(input string tag);
    logic [31:0] a;
    logic [31:0] e;
    chk({tag, "_sb_count"}, act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_sb_data"}, a, e);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_req();
    req = 1'b1;
    @(negedge clock);
    req = 1'b0;
  endtask

  initial begin
    int s0;
    int s1;
    int h;
    int n;
    bit found;

    tbl[0] = '{0, 16'h1900, 16'h3C00, 1, 16'h1900, 16'h3C00, 1'b1, 1'b0};
    tbl[1] = '{1, 16'h7700, 16'h7700, 3, 16'h1900, 16'h3C00, 1'b1, 1'b1};
    tbl[2] = '{0, 16'h2000, 16'h4000, 1, 16'h2000, 16'h4000, 1'b1, 1'b0};
    tbl[3] = '{2, 16'h2100, 16'h4100, 1, 16'h2100, 16'h4100, 1'b1, 1'b0};
    tbl[4] = '{4, 16'h2200, 16'h4200, 3, 16'h2100, 16'h4100, 1'b1, 1'b1};
    if (RANGE_EN) begin
      tbl[5] = '{3, 16'h3300, 16'h2000, 3, 16'h2100, 16'h4100, 1'b1, 1'b1};
    end else begin
      tbl[5] = '{3, 16'h3300, 16'h2000, 1, 16'h3300, 16'h2000, 1'b1, 1'b0};
    end
    tbl[6] = '{0, 16'h1900, 16'h3C00, 1, 16'h1900, 16'h3C00, 1'b1, 1'b0};

    reset  = 1'b0;
    enable = 1'b0;
    req    = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_start", sensor_start, 1'b0);
    chk("rst_temp", temperatura, 16'h0000);
    chk("rst_umid", umidade, 16'h0000);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fail", fail, 1'b0);
    chk("rst_estado", db_estado, 4'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_release_start", sensor_start, 1'b0);

    // Table of single manual reads.
    for (int i = 0; i < 7; i++) begin
      m_mode = tbl[i].mode;
      m_temp = tbl[i].temp;
      m_umid = tbl[i].umid;
      s0 = start_cnt;
      pulse_req();
      chk($sformatf("row%0d_req_latency", i), sensor_start, 1'b1);
      repeat (120) @(negedge clock);
      chk($sformatf("row%0d_starts", i), start_cnt - s0, tbl[i].starts);
      chk($sformatf("row%0d_temp", i), temperatura, tbl[i].e_temp);
      chk($sformatf("row%0d_umid", i), umidade, tbl[i].e_umid);
      chk($sformatf("row%0d_valid", i), valid, tbl[i].e_valid);
      chk($sformatf("row%0d_fail", i), fail, tbl[i].e_fail);
      chk($sformatf("row%0d_busy", i), busy, 1'b0);
      chk($sformatf("row%0d_estado", i), db_estado, 4'd0);
      drain($sformatf("row%0d", i));
    end

    // Periodic polling: constant 28-cycle start spacing.
    m_mode = 0;
    m_temp = 16'h1900;
    m_umid = 16'h3C00;
    s0 = start_cnt;
    enable = 1'b1;
    repeat (200) @(negedge clock);
    enable = 1'b0;
    repeat (60) @(negedge clock);
    n = start_cnt - s0;
    chk("en_enough_starts", (n >= 5), 1'b1);
    for (int k = 1; k < n; k++) begin
      chk($sformatf("en_spacing%0d", k), start_q[s0 + k] - start_q[s0 + k - 1], 28);
    end
    chk("en_fail", fail, 1'b0);
    drain("en");

    // req in HOLD cycle 3 is deferred to one cycle after HOLD ends.
    s0 = start_cnt;
    pulse_req();
    found = 1'b0;
    h = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clock);
      if (db_estado == 4'd4) begin
        found = 1'b1;
        h = cyc;
      end
    end
    chk("hold_reached", found, 1'b1);
    @(negedge clock);
    @(negedge clock);
    pulse_req();
    repeat (40) @(negedge clock);
    chk("hold_req_starts", start_cnt - s0, 2);
    if (start_cnt - s0 >= 2) begin
      chk("hold_req_delay", start_q[s0 + 1] - h, 21);
    end
    drain("hold_req");

    // Reset asserted during WAIT.
    pulse_req();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clock);
      if (db_estado == 4'd2) found = 1'b1;
    end
    chk("wait_reached", found, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    chk("rstw_estado", db_estado, 4'd0);
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_start", sensor_start, 1'b0);
    chk("rstw_valid", valid, 1'b0);
    chk("rstw_temp", temperatura, 16'h0000);
    s1 = start_cnt;
    reset = 1'b1;
    repeat (12) @(negedge clock);
    chk("rstw_no_start", start_cnt - s1, 0);
    chk("rstw_idle", db_estado, 4'd0);
    chk("rstw_no_capture", act_q.size(), 0);
    exp_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
